// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch stage owning the PC, one outstanding imem request, one output holding register
// Ports: clk/reset (sync, active-high); imem_req/imem_addr/imem_ready issue a fetch,
// imem_rvalid/imem_rdata return the word; instr_valid/instr/opcode/instr_pc/instr_ready hand it
// to decode; br_valid/Branch/UncondBranch/Zero/br_target redirect the PC.
module instr_fetch_unit #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [10:0]       opcode,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              br_valid,
  input  logic              Branch,
  input  logic              UncondBranch,
  input  logic              Zero,
  input  logic [ADDR_W-1:0] br_target
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, iss_addr, iss_addr_n, instr_pc_n;
  logic [31:0] instr_n;
  logic squash, squash_n, take, issue, drop;
  assign take = br_valid && (UncondBranch || (Branch && Zero));
  assign imem_req = state == S_REQ;
  assign imem_addr = pc;
  assign issue = imem_req && imem_ready;
  assign instr_valid = state == S_OUT;
  assign opcode = instr[31:21];
  // a returning word is wrong-path if a redirect happened earlier or lands this cycle
  assign drop = squash || take;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
      pc <= RESET_PC;
      squash <= 1'b0;
      iss_addr <= '0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      squash <= squash_n;
      iss_addr <= iss_addr_n;
      instr <= instr_n;
      instr_pc <= instr_pc_n;
    end
  end
  always_comb begin
    state_n = state;
    squash_n = squash;
    iss_addr_n = iss_addr;
    instr_n = instr;
    instr_pc_n = instr_pc;
    pc_n = take ? br_target & ~ADDR_W'(3) : issue ? pc + ADDR_W'(4) : pc;
    case (state)
      S_REQ: begin
        state_n = issue ? S_WAIT : S_REQ;
        squash_n = issue && take;
        iss_addr_n = issue ? pc : iss_addr;
      end
      S_WAIT: begin
        state_n = imem_rvalid ? (drop ? S_REQ : S_OUT) : S_WAIT;
        squash_n = !imem_rvalid && drop;
        instr_n = imem_rvalid && !drop ? imem_rdata : instr;
        instr_pc_n = imem_rvalid && !drop ? iss_addr : instr_pc;
      end
      S_OUT: state_n = take || instr_ready ? S_REQ : S_OUT;
      default: state_n = S_REQ;
    endcase
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a simple instruction memory model
module tb_instr_fetch_unit;
  localparam int AW = 64;
  typedef struct packed {logic [AW-1:0] pc; logic [31:0] w;} exp_t;
  logic clk = 0, reset = 1, imem_ready = 0, imem_rvalid = 0, instr_ready = 0;
  logic br_valid = 0, Branch = 0, UncondBranch = 0, Zero = 0;
  logic [31:0] imem_rdata = '0;
  logic [AW-1:0] br_target = '0;
  logic imem_req, instr_valid;
  logic [AW-1:0] imem_addr, instr_pc;
  logic [31:0] instr;
  logic [10:0] opcode;
  int checks = 0, errors = 0, mem_lat = 1;
  logic [AW-1:0] exp_addr[$];
  exp_t exp_instr[$];
  logic prev_v = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .opcode(opcode), .instr_pc(instr_pc), .instr_ready(instr_ready), .br_valid(br_valid),
    .Branch(Branch), .UncondBranch(UncondBranch), .Zero(Zero), .br_target(br_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'hF8400000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [AW-1:0] a, input bit deliver);
    exp_t e;
    exp_addr.push_back(a);
    if (deliver) begin
      e.pc = a;
      e.w = mem_word(a);
      exp_instr.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one();
    bit seen = 0;
    imem_ready = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    chk("issue_timeout", {63'd0, seen}, 1);
    step();
    imem_ready = 0;
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = instr_valid;
    end
    chk("valid_timeout", {63'd0, seen}, 1);
    step();
  endtask

  task automatic wait_req();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    chk("req_timeout", {63'd0, seen}, 1);
  endtask

  // memory model: one outstanding request, rvalid pulse mem_lat cycles after issue
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (!reset && imem_req && imem_ready) begin
        a = imem_addr;
        @(posedge clk);
        repeat (mem_lat - 1) @(posedge clk);
        #1 imem_rdata = mem_word(a);
        imem_rvalid = 1;
        @(posedge clk);
        #1 imem_rvalid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && imem_req && imem_ready) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got addr %h expected no request", imem_addr);
      end else chk("fetch_addr", imem_addr, exp_addr.pop_front());
    end
  end

  always @(negedge clk) begin
    if (instr_valid && !prev_v) begin
      if (exp_instr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_instr.pop_front();
        chk("instr", {32'd0, instr}, {32'd0, e.w});
        chk("instr_pc", instr_pc, e.pc);
        chk("opcode", {53'd0, opcode}, {53'd0, e.w[31:21]});
      end
    end
    prev_v = instr_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_req", {63'd0, imem_req}, 1);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", {63'd0, instr_valid}, 0);
    chk("rst_instr", {32'd0, instr}, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_opcode", {53'd0, opcode}, 0);
    step();
    expect_fetch(0, 1);
    issue_one();
    wait_valid();
    chk("ldur_opcode", {53'd0, opcode}, 64'h7C2);
    chk("ldur_instr", {32'd0, instr}, 64'hF8400000);
    instr_ready = 1;
    step();
    for (int k = 1; k < 3; k++) begin
      expect_fetch(4 * k, 1);
      issue_one();
      wait_valid();
    end
    instr_ready = 0;
    expect_fetch(12, 1);
    issue_one();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, instr_valid}, 1);
      chk("stall_instr", {32'd0, instr}, 64'hF84C000C);
      chk("stall_pc", instr_pc, 12);
      chk("stall_noreq", {63'd0, imem_req}, 0);
    end
    instr_ready = 1;
    step();
    @(negedge clk);
    chk("consumed_valid", {63'd0, instr_valid}, 0);
    step();
    instr_ready = 0;
    expect_fetch(16, 1);
    issue_one();
    wait_valid();
    br_valid = 1;
    UncondBranch = 1;
    br_target = 64'h103;
    instr_ready = 1;
    step();
    br_valid = 0;
    UncondBranch = 0;
    instr_ready = 0;
    @(negedge clk);
    chk("b_out_valid", {63'd0, instr_valid}, 0);
    chk("b_out_req", {63'd0, imem_req}, 1);
    chk("b_out_addr", imem_addr, 64'h100);
    step();
    mem_lat = 2;
    instr_ready = 1;
    expect_fetch(64'h100, 1);
    issue_one();
    br_valid = 1;
    Branch = 1;
    Zero = 0;
    step();
    br_valid = 0;
    Branch = 0;
    wait_valid();
    @(negedge clk);
    chk("cbz_nt_addr", imem_addr, 64'h104);
    step();
    mem_lat = 3;
    br_target = 64'h200;
    expect_fetch(64'h104, 0);
    issue_one();
    br_valid = 1;
    Branch = 1;
    Zero = 1;
    step();
    br_valid = 0;
    Branch = 0;
    Zero = 0;
    wait_req();
    chk("cbz_t_addr", imem_addr, 64'h200);
    chk("cbz_t_valid", {63'd0, instr_valid}, 0);
    step();
    expect_fetch(64'h200, 1);
    issue_one();
    wait_valid();
    mem_lat = 1;
    br_target = 64'h300;
    expect_fetch(64'h204, 0);
    imem_ready = 1;
    br_valid = 1;
    UncondBranch = 1;
    step();
    imem_ready = 0;
    br_valid = 0;
    UncondBranch = 0;
    wait_req();
    chk("same_cyc_addr", imem_addr, 64'h300);
    chk("same_cyc_valid", {63'd0, instr_valid}, 0);
    step();
    expect_fetch(64'h300, 1);
    issue_one();
    wait_valid();
    mem_lat = 4;
    br_target = 64'h400;
    expect_fetch(64'h304, 0);
    issue_one();
    br_valid = 1;
    UncondBranch = 1;
    step();
    br_valid = 0;
    UncondBranch = 0;
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("mid_rst_req", {63'd0, imem_req}, 1);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_instr", {32'd0, instr}, 0);
    chk("mid_rst_pc", instr_pc, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_hold_valid", {63'd0, instr_valid}, 0);
      chk("mid_rst_hold_addr", imem_addr, 0);
    end
    step();
    expect_fetch(0, 1);
    issue_one();
    wait_valid();
    repeat (3) step();
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("instr_queue_empty", exp_instr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
